// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: default widths,
// FSM state encoding and the iteration-counter width helper.
package div_pkg;

  localparam int unsigned WA_DEF = 8;
  localparam int unsigned WB_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Counter must be able to represent 0..WA
  function automatic int unsigned cnt_width(input int unsigned wa);
    return $clog2(wa + 1);
  endfunction

  localparam int unsigned CNT_W_DEF = $clog2(WA_DEF + 1);

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module div_step #(
  parameter int unsigned WB = 4
) (
  input  logic [WB:0]   rem_i,
  input  logic          qmsb_i,
  input  logic [WB-1:0] b_i,
  output logic [WB:0]   rem_o,
  output logic          qbit_o
);

  logic [WB:0]   shifted;
  logic [WB+1:0] trial;

  always_comb begin
    shifted = {rem_i[WB-1:0], qmsb_i};
    // Extra top bit acts as the borrow/sign of the trial subtraction
    trial   = {1'b0, shifted} - {2'b00, b_i};
    qbit_o  = ~trial[WB+1];
    rem_o   = qbit_o ? trial[WB:0] : shifted;
  end

endmodule

// File: rtl/div.sv
// Sequential unsigned divider, one quotient bit per clock behind a
// start/busy handshake; q/r are registered and update only on completion.
module div
  import div_pkg::*;
#(
  parameter int unsigned WA = WA_DEF,
  parameter int unsigned WB = WB_DEF
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [WA-1:0] a,
  input  logic [WB-1:0] b,
  input  logic          start,
  output logic [WA-1:0] q,
  output logic [WB-1:0] r,
  output logic          busy
);

  localparam int unsigned CW = cnt_width(WA);
  localparam logic [CW-1:0] LAST = CW'(WA - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WB:0]   rem_q, rem_d;
  logic [WA-1:0] quo_q, quo_d;
  logic [WB-1:0] dvs_q, dvs_d;
  logic [WA-1:0] q_q, q_d;
  logic [WB-1:0] r_q, r_d;

  logic [WB:0]   step_rem;
  logic          step_qbit;

  div_step #(
    .WB (WB)
  ) u_step (
    .rem_i  (rem_q),
    .qmsb_i (quo_q[WA-1]),
    .b_i    (dvs_q),
    .rem_o  (step_rem),
    .qbit_o (step_qbit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    q_d     = q_q;
    r_d     = r_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          quo_d   = a;
          dvs_d   = b;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        rem_d = step_rem;
        quo_d = {quo_q[WA-2:0], step_qbit};
        cnt_d = cnt_q + 1'b1;
        // Final step publishes the freshly computed values, not the stale regs
        if (cnt_q == LAST) begin
          q_d     = {quo_q[WA-2:0], step_qbit};
          r_d     = step_rem[WB-1:0];
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      q_q     <= q_d;
      r_q     <= r_d;
    end
  end

  assign q    = q_q;
  assign r    = r_q;
  assign busy = (state_q == BUSY);

endmodule

// File: tb/tb_div.sv
// Directed self-checking bench for the sequential divider.
module tb_div;

  logic       clk;
  logic       resetn;
  logic [7:0] a;
  logic [3:0] b;
  logic       start;
  logic [7:0] q;
  logic [3:0] r;
  logic       busy;

  int errors = 0;
  int checks = 0;

  div #(
    .WA (8),
    .WB (4)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .a      (a),
    .b      (b),
    .start  (start),
    .q      (q),
    .r      (r),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for exactly one rising edge; returns just after that edge.
  task automatic launch(input logic [7:0] av, input logic [3:0] bv);
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count negedge samples with busy high (bounded), noting whether q/r moved.
  task automatic wait_done(input logic [7:0] pq, input logic [3:0] pr,
                           output int cycles, output bit held);
    cycles = 0;
    held = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) break;
      cycles++;
      if (q !== pq || r !== pr) held = 1'b0;
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (q !== 8'd0) begin errors++; $display("FAIL reset_q: got %0d want 0", q); end
    checks++;
    if (r !== 4'd0) begin errors++; $display("FAIL reset_r: got %0d want 0", r); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy_rel: got %0b want 0", busy); end
  endtask

  task automatic test_vectors;
    logic [7:0] va [6] = '{8'd16, 8'd24, 8'd6, 8'd255, 8'd6, 8'd6};
    logic [3:0] vb [6] = '{4'd4, 4'd11, 4'd5, 4'd15, 4'd15, 4'd0};
    logic [7:0] eq [6] = '{8'd4, 8'd2, 8'd1, 8'd17, 8'd0, 8'hFF};
    logic [3:0] er [6] = '{4'd0, 4'd2, 4'd1, 4'd0, 4'd6, 4'd6};
    int  cyc;
    bit  held;
    logic [7:0] pq;
    logic [3:0] pr;
    for (int i = 0; i < 6; i++) begin
      pq = q;
      pr = r;
      launch(va[i], vb[i]);
      a = ~va[i];
      b = ~vb[i];
      wait_done(pq, pr, cyc, held);
      checks++;
      if (cyc != 8) begin errors++; $display("FAIL vec%0d_busy_cycles: got %0d want 8", i, cyc); end
      checks++;
      if (!held) begin errors++; $display("FAIL vec%0d_hold: q/r changed while busy, want %0d/%0d", i, pq, pr); end
      checks++;
      if (q !== eq[i]) begin errors++; $display("FAIL vec%0d_q: %0d/%0d got q=%0d want %0d", i, va[i], vb[i], q, eq[i]); end
      checks++;
      if (r !== er[i]) begin errors++; $display("FAIL vec%0d_r: %0d/%0d got r=%0d want %0d", i, va[i], vb[i], r, er[i]); end
    end
  endtask

  task automatic test_start_held;
    int cyc;
    bit held;
    logic [7:0] pq;
    logic [3:0] pr;
    pq = q;
    pr = r;
    @(negedge clk);
    a = 8'd100;
    b = 4'd7;
    start = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 start = 1'b0;
    a = 8'd3;
    b = 4'd1;
    // One busy cycle already elapsed while start was still held
    wait_done(pq, pr, cyc, held);
    checks++;
    if (cyc != 7) begin errors++; $display("FAIL held_busy_cycles: got %0d want 7", cyc); end
    checks++;
    if (q !== 8'd14) begin errors++; $display("FAIL held_q: got %0d want 14", q); end
    checks++;
    if (r !== 4'd2) begin errors++; $display("FAIL held_r: got %0d want 2", r); end
  endtask

  task automatic test_mid_busy;
    int cyc;
    bit held;
    logic [7:0] pq;
    logic [3:0] pr;
    pq = q;
    pr = r;
    launch(8'd200, 4'd9);
    repeat (3) @(negedge clk);
    a = 8'd1;
    b = 4'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %0b want 1", busy); end
    checks++;
    if (q !== pq || r !== pr) begin errors++; $display("FAIL mid_hold: got %0d/%0d want %0d/%0d", q, r, pq, pr); end
    wait_done(pq, pr, cyc, held);
    checks++;
    if (cyc != 4 || !held) begin errors++; $display("FAIL mid_tail: got cycles=%0d held=%0b want 4/1", cyc, held); end
    checks++;
    if (q !== 8'd22 || r !== 4'd2) begin errors++; $display("FAIL mid_result: got %0d/%0d want 22/2", q, r); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    bit held;
    logic [7:0] pq;
    logic [3:0] pr;
    pq = q;
    pr = r;
    @(negedge clk);
    a = 8'd77;
    b = 4'd8;
    start = 1'b1;
    @(posedge clk);
    #1;
    a = 8'd50;
    b = 4'd3;
    wait_done(pq, pr, cyc, held);
    checks++;
    if (cyc != 8) begin errors++; $display("FAIL b2b_first_cycles: got %0d want 8", cyc); end
    checks++;
    if (q !== 8'd9 || r !== 4'd5) begin errors++; $display("FAIL b2b_first: got %0d/%0d want 9/5", q, r); end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_reaccept: got busy=%0b want 1", busy); end
    wait_done(8'd9, 4'd5, cyc, held);
    checks++;
    if (cyc != 7 || !held) begin errors++; $display("FAIL b2b_second_cycles: got %0d held=%0b want 7/1", cyc, held); end
    checks++;
    if (q !== 8'd16 || r !== 4'd2) begin errors++; $display("FAIL b2b_second: got %0d/%0d want 16/2", q, r); end
  endtask

  task automatic test_reset_mid;
    bit stayed;
    launch(8'd16, 4'd4);
    repeat (3) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (q !== 8'd0 || r !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: got q=%0d r=%0d busy=%0b want 0/0/0", q, r, busy);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    stayed = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || q !== 8'd0 || r !== 4'd0) stayed = 1'b0;
    end
    checks++;
    if (!stayed) begin errors++; $display("FAIL rst_abort: got q=%0d r=%0d busy=%0b want 0/0/0", q, r, busy); end
  endtask

  initial begin
    test_reset;
    test_vectors;
    test_start_held;
    test_mid_busy;
    test_back_to_back;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
